stack_op_sequencer: RTL and testbench

//  Upstream command stage for the 16x8 on-chip stack. Accepts one opcode at a time over
//  a valid/ready handshake and expands it into push/pop pulses to the stack, waiting for
//  the stack's done strobe after each. Computes binary ALU results from the two popped

---
 rtl/stack_pkg.sv | 40 ++++
 rtl/stack_op_alu.sv | 26 ++
 rtl/stack_op_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack command sequencer: default sizes, opcode
// encodings, FSM state encoding and the operand-count helper.
package stack_pkg;

  localparam int unsigned STK_DATA_W  = 8;
  localparam int unsigned STK_DEPTH   = 16;
  localparam int unsigned STK_TIMEOUT = 15;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CHECK  = 4'd1,
    S_POP_B  = 4'd2,
    S_WAIT_B = 4'd3,
    S_POP_A  = 4'd4,
    S_WAIT_A = 4'd5,
    S_EXEC   = 4'd6,
    S_PUSH_R = 4'd7,
    S_WAIT_R = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  // Number of stack words an opcode consumes before it can run.
  function automatic logic [1:0] pops_needed(input logic [2:0] op);
    case (op)
      OP_POP, OP_DUP:                 return 2'd1;
      OP_ADD, OP_SUB, OP_AND, OP_XOR: return 2'd2;
      default:                        return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_op_alu.sv
// Combinational result generator: binary ops on the two popped operands
// (A = older word, B = former top); DUP and everything else pass B through.
module stack_op_alu
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = STK_DATA_W
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  // Wrap-around arithmetic, no carry out
  always_comb begin
    y_o = b_i;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = b_i;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Expands one opcode at a time into push/pop pulses to the on-chip stack,
// tracking occupancy locally so overflow/underflow never reach the stack.
module stack_op_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W  = STK_DATA_W,
  parameter int unsigned DEPTH   = STK_DEPTH,
  parameter int unsigned TIMEOUT = STK_TIMEOUT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic [2:0]                   op_code_i,
  input  logic [DATA_W-1:0]            op_imm_i,
  output logic                         stk_push_o,
  output logic                         stk_pop_o,
  output logic [DATA_W-1:0]            stk_wdata_o,
  input  logic [DATA_W-1:0]            stk_rdata_i,
  input  logic                         stk_done_i,
  output logic                         res_valid_o,
  output logic [DATA_W-1:0]            res_data_o,
  output logic                         res_err_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic                dup2_q, dup2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic                op_ready_q, stk_push_q, stk_pop_q, res_valid_q;
  logic [DATA_W-1:0]   stk_wdata_q;
  logic [DATA_W-1:0]   alu_y_s;
  logic                underflow_s, overflow_s, timed_out_s;

  stack_op_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y_s)
  );

  assign underflow_s = depth_q < DEPTH_W'(pops_needed(op_q));
  assign overflow_s  = ((op_q == OP_PUSH) || (op_q == OP_DUP)) && (depth_q == DEPTH_W'(DEPTH));
  assign timed_out_s = cnt_q == CNT_W'(TIMEOUT - 1);

  // Next-state, operand capture, depth tracking and result selection
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    dup2_d     = dup2_q;
    cnt_d      = cnt_q;
    depth_d    = depth_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid_i && op_ready_q) begin
          state_d = S_CHECK;
          op_d    = op_code_i;
          r_d     = op_imm_i;
          dup2_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (underflow_s || overflow_s) begin
          state_d    = S_DONE;
          res_data_d = {DATA_W{1'b0}};
          res_err_d  = 1'b1;
        end else if (op_q == OP_NOP) begin
          state_d    = S_DONE;
          res_data_d = {DATA_W{1'b0}};
          res_err_d  = 1'b0;
        end else if (op_q == OP_PUSH) begin
          state_d = S_PUSH_R;
        end else begin
          state_d = S_POP_B;
        end
      end
      S_POP_B: begin
        state_d = S_WAIT_B;
        cnt_d   = {CNT_W{1'b0}};
      end
      S_WAIT_B: begin
        if (stk_done_i) begin
          depth_d = depth_q - DEPTH_W'(1);
          b_d     = stk_rdata_i;
          if (op_q == OP_POP) begin
            state_d    = S_DONE;
            res_data_d = stk_rdata_i;
            res_err_d  = 1'b0;
          end else if (op_q == OP_DUP) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_POP_A;
          end
        end else if (timed_out_s) begin
          state_d    = S_DONE;
          res_data_d = {DATA_W{1'b0}};
          res_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POP_A: begin
        state_d = S_WAIT_A;
        cnt_d   = {CNT_W{1'b0}};
      end
      S_WAIT_A: begin
        if (stk_done_i) begin
          depth_d = depth_q - DEPTH_W'(1);
          a_d     = stk_rdata_i;
          state_d = S_EXEC;
        end else if (timed_out_s) begin
          state_d    = S_DONE;
          res_data_d = {DATA_W{1'b0}};
          res_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        r_d     = alu_y_s;
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        state_d = S_WAIT_R;
        cnt_d   = {CNT_W{1'b0}};
      end
      S_WAIT_R: begin
        if (stk_done_i) begin
          if (depth_q != DEPTH_W'(DEPTH)) begin
            depth_d = depth_q + DEPTH_W'(1);
          end else begin
            depth_d = depth_q;
          end
          if ((op_q == OP_DUP) && !dup2_q) begin
            state_d = S_PUSH_R;
            dup2_d  = 1'b1;
          end else begin
            state_d    = S_DONE;
            res_data_d = r_q;
            res_err_d  = 1'b0;
          end
        end else if (timed_out_s) begin
          state_d    = S_DONE;
          res_data_d = {DATA_W{1'b0}};
          res_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/stack outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      r_q         <= {DATA_W{1'b0}};
      dup2_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      depth_q     <= {DEPTH_W{1'b0}};
      res_data_q  <= {DATA_W{1'b0}};
      res_err_q   <= 1'b0;
      op_ready_q  <= 1'b1;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_wdata_q <= {DATA_W{1'b0}};
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      dup2_q      <= dup2_d;
      cnt_q       <= cnt_d;
      depth_q     <= depth_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      op_ready_q  <= (state_d == S_IDLE);
      stk_push_q  <= (state_d == S_PUSH_R);
      stk_pop_q   <= (state_d == S_POP_B) || (state_d == S_POP_A);
      stk_wdata_q <= (state_d == S_PUSH_R) ? r_d : {DATA_W{1'b0}};
      res_valid_q <= (state_d == S_DONE);
    end
  end

  assign op_ready_o  = op_ready_q;
  assign stk_push_o  = stk_push_q;
  assign stk_pop_o   = stk_pop_q;
  assign stk_wdata_o = stk_wdata_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;
  assign depth_o     = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboard bench: directed opcodes against a behavioural 16x8 stack model.
module tb_stack_op_sequencer;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, AND_ = 3'd5, XOR_ = 3'd6, DUP = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_ready;
  logic [2:0] op_code;
  logic [7:0] op_imm;
  logic       stk_push, stk_pop;
  logic [7:0] stk_wdata, stk_rdata;
  logic       stk_done;
  logic       res_valid, res_err;
  logic [7:0] res_data;
  logic [4:0] depth;

  stack_op_sequencer dut (
    .clk_i(clk), .rst_i(rst), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_code_i(op_code), .op_imm_i(op_imm), .stk_push_o(stk_push), .stk_pop_o(stk_pop),
    .stk_wdata_o(stk_wdata), .stk_rdata_i(stk_rdata), .stk_done_i(stk_done),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_err_o(res_err), .depth_o(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [4:0] dep;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_push[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_acc = 0, last_push_cyc = 0, last_res_cyc = 0;
  int pushes_seen = 0, pops_seen = 0;
  logic       withhold = 1'b0;
  logic [7:0] mem [16];
  int         sp = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stack model: one-cycle done, or silently ignores requests while withhold is set
  always @(posedge clk) begin
    stk_done <= 1'b0;
    if (rst) begin
      sp <= 0;
    end else if (!withhold) begin
      if (stk_push && sp < 16) begin
        mem[sp] <= stk_wdata;
        sp <= sp + 1;
        stk_done <= 1'b1;
      end else if (stk_pop && sp > 0) begin
        stk_rdata <= mem[sp-1];
        sp <= sp - 1;
        stk_done <= 1'b1;
      end
    end
  end

  // Monitor: compares results and pushed words against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (stk_push && stk_pop) check("push_pop_exclusive", 32'd1, 32'd0);
      if (stk_push) begin
        pushes_seen++;
        last_push_cyc = cyc;
        if (exp_push.size() == 0) check("push_unexpected", 32'd1, 32'd0);
        else check("push_data", {24'd0, stk_wdata}, {24'd0, exp_push.pop_front()});
      end
      if (stk_pop) pops_seen++;
      if (res_valid) begin
        exp_t e;
        last_res_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("res_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_err", {31'd0, res_err}, {31'd0, e.err});
          if (!e.err) check("res_data", {24'd0, res_data}, {24'd0, e.data});
          check("res_depth", {27'd0, depth}, {27'd0, e.dep});
        end
      end
    end
  end

  task automatic expect_res(input logic [7:0] d, input logic e, input logic [4:0] dp);
    exp_t x;
    x.data = d; x.err = e; x.dep = dp;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] imm);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_imm = imm;
    n = 0;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check("accept_timeout", 32'd0, 32'd1);
    t_acc = cyc;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && op_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; withhold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = NOP; op_imm = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_depth", {27'd0, depth}, 32'd0);
    check("rst_outputs", {28'd0, res_valid, res_err, stk_push, stk_pop}, 32'd0);

    // SUB: 5 - 3 with operand order A=older, B=top
    expect_res(8'h05, 1'b0, 5'd1); exp_push.push_back(8'h05);
    issue(PUSH, 8'h05); wait_idle();
    check("push_latency", last_push_cyc - t_acc, 32'd2);
    check("res_latency", last_res_cyc - t_acc, 32'd4);
    expect_res(8'h03, 1'b0, 5'd2); exp_push.push_back(8'h03);
    issue(PUSH, 8'h03);
    expect_res(8'h02, 1'b0, 5'd1); exp_push.push_back(8'h02);
    issue(SUB, 8'h00); wait_idle();

    // ADD wrap-around, DUP, NOP
    do_reset();
    expect_res(8'hF0, 1'b0, 5'd1); exp_push.push_back(8'hF0); issue(PUSH, 8'hF0);
    expect_res(8'h20, 1'b0, 5'd2); exp_push.push_back(8'h20); issue(PUSH, 8'h20);
    expect_res(8'h10, 1'b0, 5'd1); exp_push.push_back(8'h10); issue(ADD, 8'h00);
    expect_res(8'h10, 1'b0, 5'd2); exp_push.push_back(8'h10); exp_push.push_back(8'h10);
    issue(DUP, 8'h00);
    expect_res(8'h00, 1'b0, 5'd2); issue(NOP, 8'h55);
    expect_res(8'hC3, 1'b0, 5'd3); exp_push.push_back(8'hC3); issue(PUSH, 8'hC3);
    expect_res(8'hD3, 1'b0, 5'd2); exp_push.push_back(8'hD3); issue(XOR_, 8'h00);
    expect_res(8'h10, 1'b0, 5'd1); exp_push.push_back(8'h10); issue(AND_, 8'h00);
    wait_idle();

    // Underflow straight after reset
    do_reset();
    begin
      int p0;
      p0 = pops_seen;
      expect_res(8'h00, 1'b1, 5'd0); issue(POP, 8'h00); wait_idle();
      check("underflow_latency", last_res_cyc - t_acc, 32'd2);
      check("underflow_no_pop", pops_seen, p0);
    end

    // Fill to 16, then overflow on PUSH and DUP, then a legal POP
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = 8'h10 + 8'(i);
      expect_res(v, 1'b0, 5'(i + 1)); exp_push.push_back(v); issue(PUSH, v);
    end
    wait_idle();
    begin
      int p0;
      p0 = pushes_seen;
      expect_res(8'h00, 1'b1, 5'd16); issue(PUSH, 8'hAA);
      expect_res(8'h00, 1'b1, 5'd16); issue(DUP, 8'h00); wait_idle();
      check("overflow_no_push", pushes_seen, p0);
      check("overflow_depth", {27'd0, depth}, 32'd16);
    end
    expect_res(8'h1F, 1'b0, 5'd15); issue(POP, 8'h00); wait_idle();

    // Stack never answers a POP
    do_reset();
    expect_res(8'h77, 1'b0, 5'd1); exp_push.push_back(8'h77); issue(PUSH, 8'h77); wait_idle();
    withhold = 1'b1;
    expect_res(8'h00, 1'b1, 5'd1); issue(POP, 8'h00); wait_idle();
    check("timeout_latency", last_res_cyc - t_acc, 32'd18);
    check("timeout_ready", {31'd0, op_ready}, 32'd1);
    withhold = 1'b0;
    expect_res(8'h77, 1'b0, 5'd0); issue(POP, 8'h00); wait_idle();

    // Reset while the XOR waits for its second pop
    do_reset();
    expect_res(8'h0C, 1'b0, 5'd1); exp_push.push_back(8'h0C); issue(PUSH, 8'h0C);
    expect_res(8'h0A, 1'b0, 5'd2); exp_push.push_back(8'h0A); issue(PUSH, 8'h0A); wait_idle();
    issue(XOR_, 8'h00);
    begin
      int np, n;
      np = 0; n = 0;
      while (np < 2 && n < 50) begin
        if (stk_pop) np++;
        if (np < 2) begin
          @(negedge clk);
          n++;
        end
      end
      check("xor_second_pop_seen", np, 32'd2);
      withhold = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_op_ready", {31'd0, op_ready}, 32'd1);
      check("midrst_depth", {27'd0, depth}, 32'd0);
      check("midrst_no_res", {31'd0, res_valid}, 32'd0);
      rst = 1'b0; withhold = 1'b0;
      repeat (4) @(negedge clk);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("push_queue_empty", exp_push.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
